psum_reduce_tree: RTL
=====================

# psum_reduce_tree

Parametrised, pipelined successor of the single-cycle column adder. Reduces a `ROWS x COLS` block of PE partial sums to `COLS` column sums through a registered binary tree, with valid/ready handshaking and backpressure. An optional accumulate mode sums column results across several input beats, such as K-dimension tiles, before emitting. Sits between the PE array output and the post-processing / output buffer.

## Interface
Parameters:
- `ROWS`, 8: PE rows reduced per column; power of two, ≥ 2.
- `COLS`, 8: independent column channels.
- `DW`, 32: input and output data width, two's complement.
- `SAT`, 0: 0 = wrap modulo 2^DW; 1 = signed saturation at the accumulator stage.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: block can accept a beat.
- `in_data`, in, `DW x ROWS*COLS`: element `r*COLS + c` is row r, column c.
- `in_acc`, in, 1: beat belongs to an accumulation group.
- `in_last`, in, 1: final beat of a group; ignored when `in_acc`=0.
- `out_valid`, out, 1: column sums valid.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, `DW x COLS`: column sums.
- `acc_busy`, out, 1: an accumulation group is open (partial held).
- `sat_flag`, out, 1: sticky; set when any saturation occurred (only when `SAT`=1). Cleared by reset only.

## Operation
- Tree: L = $clog2(ROWS) register stages. Stage k adds adjacent pairs of stage k-1 per column. Each stage carries valid, acc, last sidebands. Stage adds wrap at DW bits.
- Global advance: `adv = !(out_valid && !out_ready)`; `in_ready = adv`. All stages and the output register move only when `adv`=1. A beat is accepted when `in_valid && in_ready`.
- Accumulator stage, acting on a tree-output beat when `adv`=1:
  - `acc`=0: `out_data` = tree sum, `out_valid` = 1. The accumulator is untouched.
  - `acc`=1, `last`=0: partial = partial + tree. `out_valid` goes 0 if the previous output was consumed. `acc_busy` = 1.
  - `acc`=1, `last`=1: `out_data` = partial + tree, `out_valid` = 1, partial = 0, `acc_busy` = 0.
- A non-acc beat arriving while a group is open passes through as a plain result. The open partial is preserved.
- When `adv`=1 and no tree beat is arriving, `out_valid` goes 0.
- Saturation (`SAT`=1): the accumulator add clamps to [-2^(DW-1), 2^(DW-1)-1] and sets `sat_flag`. Tree stages always wrap.

## Timing
- Reset values: `out_valid` 0, `out_data` all 0, all stage valids 0, partials 0, `acc_busy` 0, `sat_flag` 0. `in_ready` reads 1 during reset, since `out_valid`=0.
- Latency: a beat accepted at edge t produces `out_valid` at edge t+L+1, or 4 cycles at ROWS=8, when no stall occurs.
- Throughput: 1 beat/cycle with `out_ready` held at 1.
- Stall: `out_ready`=0 with `out_valid`=1 freezes every stage. `out_data` is held stable and no beat is lost or duplicated.
- Output change: `out_valid` may deassert only after a handshake.
- Reset mid-operation: all in-flight beats and any open partial are discarded.

## Structure
- Package `psum_pkg`: default `ROWS`/`COLS`/`DW` localparams, the sideband struct type (valid, acc, last), and the saturating-add function.
- Sub-module `psum_tree_stage`: one registered pairwise-add level, parametrised on input count, with the sideband pass-through and an `adv` enable. Instantiate it L times via generate.

## Test plan
- Single beat: ROWS=8, COLS=8, `in_data[r*8+c] = r+c`, `in_acc`=0 → after 4 cycles `out_data[c]` = 28+8c, `out_valid` high for 1 cycle.
- Streaming: 16 back-to-back beats, `out_ready`=1 → 16 consecutive outputs in order, correct sums, `in_ready` never drops.
- Backpressure: drop `out_ready` for 5 cycles mid-stream → `out_data` is stable, `in_ready`=0, and after release no lost or duplicated results.
- Accumulate: 3 beats, all elements 1, `in_acc`=1, last on the 3rd → one output with each column = 24. `acc_busy` is 1 between beats and 0 after.
- Wrap vs saturate: with `SAT`=0, two acc beats each giving column sum 0x7FFFFFF0 → 0xFFFFFFE0. With `SAT`=1 → 0x7FFFFFFF and `sat_flag`=1.
- Reset mid-group: assert `rst`=0 after 1 acc beat, release, then send one acc+last beat of all 1s → output 8 per column, the old partial discarded.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum reduction tree.
// Holds default geometry, the stage sideband bundle and the saturating add.
package psum_pkg;

    localparam int ROWS_DEF = 8;
    localparam int COLS_DEF = 8;
    localparam int DW_DEF   = 32;

    typedef struct packed {
        logic valid;
        logic acc;
        logic last;
    } sb_t;

    // Bit offset of tree level k inside the flat level bus.
    // Level j holds (rows >> j) rows of cols words each.
    function automatic int lvl_off(
        input int rows,
        input int cols,
        input int dw,
        input int k
    );
        return (2 * rows - 2 * (rows >> k)) * cols * dw;
    endfunction

    // Operands are sign-extended dw-bit values, so the 64-bit sum
    // cannot overflow for dw < 64.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 dw
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

    function automatic logic sat_hit(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 dw
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        return (s > hi) || (s < lo);
    endfunction

endpackage

// File: rtl/psum_tree_stage.sv
// One registered pairwise-add level of the column reduction tree.
// Ports: clk, rst (sync active-low), i_adv enable, i_data/i_sb in,
// o_data/o_sb registered out (half the rows of the input).
module psum_tree_stage
    import psum_pkg::*;
#(
    parameter int NIN  = 8,
    parameter int COLS = 8,
    parameter int DW   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_adv,
    input  logic [NIN*COLS*DW-1:0]       i_data,
    input  sb_t                          i_sb,
    output logic [(NIN/2)*COLS*DW-1:0]   o_data,
    output sb_t                          o_sb
);

    localparam int NOUT = NIN / 2;

    logic [NOUT*COLS*DW-1:0] w_sum;
    logic [NOUT*COLS*DW-1:0] r_data;
    sb_t                     r_sb;

    // Output row r, column c sums input rows 2r and 2r+1 of column c.
    for (genvar r = 0; r < NOUT; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign w_sum[(r*COLS+c)*DW +: DW] =
                i_data[((2*r)*COLS+c)*DW +: DW] +
                i_data[((2*r+1)*COLS+c)*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
            r_sb   <= '0;
        end else if (i_adv) begin
            r_data <= w_sum;
            r_sb   <= i_sb;
        end
    end

    assign o_data = r_data;
    assign o_sb   = r_sb;

endmodule

// File: rtl/psum_reduce_tree.sv
// Pipelined ROWS x COLS partial-sum reducer with optional accumulation.
// Ports: clk, rst (sync active-low); in_valid/in_ready/in_data/in_acc/
// in_last beat input; out_valid/out_ready/out_data column sums;
// acc_busy (group open), sat_flag (sticky saturation seen).
module psum_reduce_tree
    import psum_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int DW   = DW_DEF,
    parameter int SAT  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*COLS*DW-1:0] in_data,
    input  logic                    in_acc,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*DW-1:0]      out_data,
    output logic                    acc_busy,
    output logic                    sat_flag
);

    localparam int L  = $clog2(ROWS);
    localparam int CW = COLS * DW;
    localparam int LW = (2 * ROWS - 1) * CW;

    logic          w_adv;
    logic [LW-1:0] w_lvl;
    sb_t           w_sb [0:L];
    logic [CW-1:0] w_tree;
    sb_t           w_tsb;
    logic [CW-1:0] w_accsum;
    logic [COLS-1:0] w_satc;

    logic          r_out_valid;
    logic [CW-1:0] r_out_data;
    logic [CW-1:0] r_part;
    logic          r_busy;
    logic          r_sat;

    // Whole pipeline stalls only while a valid result waits downstream.
    assign w_adv    = !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    assign w_lvl[ROWS*CW-1:0] = in_data;
    assign w_sb[0] = '{valid: in_valid, acc: in_acc, last: in_last};

    for (genvar k = 1; k <= L; k++) begin : g_st
        localparam int NIN = ROWS >> (k - 1);
        localparam int OI  = lvl_off(ROWS, COLS, DW, k - 1);
        localparam int OO  = lvl_off(ROWS, COLS, DW, k);
        psum_tree_stage #(
            .NIN  (NIN),
            .COLS (COLS),
            .DW   (DW)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_adv  (w_adv),
            .i_data (w_lvl[OI +: NIN*CW]),
            .i_sb   (w_sb[k-1]),
            .o_data (w_lvl[OO +: (NIN/2)*CW]),
            .o_sb   (w_sb[k])
        );
    end

    assign w_tree = w_lvl[LW-1 -: CW];
    assign w_tsb  = w_sb[L];

    always_comb begin
        w_accsum = '0;
        w_satc   = '0;
        for (int c = 0; c < COLS; c++) begin
            if (SAT != 0) begin
                w_accsum[c*DW +: DW] = DW'(sat_add(
                    64'($signed(r_part[c*DW +: DW])),
                    64'($signed(w_tree[c*DW +: DW])), DW));
                w_satc[c] = sat_hit(
                    64'($signed(r_part[c*DW +: DW])),
                    64'($signed(w_tree[c*DW +: DW])), DW);
            end else begin
                w_accsum[c*DW +: DW] = r_part[c*DW +: DW] +
                                       w_tree[c*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_part      <= '0;
            r_busy      <= 1'b0;
            r_sat       <= 1'b0;
        end else if (w_adv) begin
            unique case (1'b1)
                !w_tsb.valid: begin
                    r_out_valid <= 1'b0;
                end
                w_tsb.valid && !w_tsb.acc: begin
                    // Plain beat; an open partial is left alone.
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_tree;
                end
                w_tsb.valid && w_tsb.acc && !w_tsb.last: begin
                    r_out_valid <= 1'b0;
                    r_part      <= w_accsum;
                    r_busy      <= 1'b1;
                    r_sat       <= r_sat | (|w_satc);
                end
                w_tsb.valid && w_tsb.acc && w_tsb.last: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_accsum;
                    r_part      <= '0;
                    r_busy      <= 1'b0;
                    r_sat       <= r_sat | (|w_satc);
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign acc_busy  = r_busy;
    assign sat_flag  = r_sat;

endmodule
